// File: rtl/trace_recorder.sv
// Commit-trace recorder: captures writeback/store retire events with cycle
// timestamps into a first-word-fall-through FIFO and detects timeout/halt.
module trace_recorder #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int CYC_W       = 32,
  parameter int MAX_CYCLES  = 2000,
  parameter int HALT_REPEAT = 4,
  parameter int OVERWRITE   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [XLEN-1:0]          pc,
  input  logic [XLEN-1:0]          pc_next,
  input  logic                     reg_write,
  input  logic [4:0]               rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     mem_write,
  input  logic [XLEN-1:0]          mem_addr,
  input  logic [XLEN-1:0]          mem_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYC_W-1:0]         out_cycle,
  output logic [XLEN-1:0]          out_pc,
  output logic [1:0]               out_kind,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_wb_data,
  output logic [XLEN-1:0]          out_mem_addr,
  output logic [XLEN-1:0]          out_mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [CYC_W-1:0]         cycles,
  output logic                     done,
  output logic                     timeout,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam bit OW = (OVERWRITE != 0);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);
  localparam logic [RW-1:0]    LAST_REP = RW'(HALT_REPEAT - 1);

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

  typedef struct packed {
    logic [CYC_W-1:0] cyc;
    logic [XLEN-1:0]  pc;
    logic [1:0]       kind;
    logic [4:0]       rd;
    logic [XLEN-1:0]  wb;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
  } entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          state, state_nx;
  entry_t          mem [DEPTH];
  entry_t          head_e;
  logic [AW-1:0]   head, tail;
  logic [RW-1:0]   rep;
  logic            push, pop, full, lose, wr_en, head_adv;
  logic            self_loop, halt_det, timeout_det;

  always_comb begin
    push        = (state == RUN) && en && (reg_write || mem_write);
    pop         = (count != '0) && out_ready;
    full        = (count == FULL_CNT);
    lose        = push && !pop && full;
    wr_en       = push && (!full || pop || OW);
    head_adv    = pop || (lose && OW);
    self_loop   = en && (pc_next == pc);
    halt_det    = (state == RUN) && self_loop && (rep == LAST_REP);
    timeout_det = (state == RUN) && (cycles == LAST_CYC);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == RUN && (timeout_det || halt_det)) state_nx = DONE;
  end

  always_comb begin
    done          = (state == DONE);
    out_valid     = (count != '0);
    head_e        = mem[head];
    out_cycle     = head_e.cyc;
    out_pc        = head_e.pc;
    out_kind      = head_e.kind;
    out_rd        = head_e.rd;
    out_wb_data   = head_e.wb;
    out_mem_addr  = head_e.addr;
    out_mem_wdata = head_e.wdata;
  end

  // Entry storage carries no reset; only pointers/count qualify its contents.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[tail] <= '{cyc: cycles, pc: pc, kind: {mem_write, reg_write}, rd: rd,
                     wb: wb_data, addr: mem_addr, wdata: mem_wdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_en)    tail <= tail + AW'(1);
      if (head_adv) head <= head + AW'(1);
      if (push && !pop && !full)  count <= count + (AW+1)'(1);
      else if (pop && !push)      count <= count - (AW+1)'(1);
      if (lose) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles  <= '0;
      rep     <= '0;
      timeout <= 1'b0;
      halted  <= 1'b0;
    end else if (state == RUN) begin
      cycles <= cycles + CYC_W'(1);
      if (en) rep <= self_loop ? rep + RW'(1) : '0;
      if (timeout_det) timeout <= 1'b1;
      if (halt_det)    halted  <= 1'b1;
    end
  end

endmodule
